// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-AEAD128 decryption controller.
package ascon_pack;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      INIT_P,
      KEY_INIT,
      WAIT_AD,
      AD_P,
      DOMAIN,
      WAIT_CT,
      CT_P,
      KEY_FIN,
      FIN_P,
      TAG
   } state_t;

   // pa runs rounds 0..11, pb runs rounds 4..11
   localparam logic [3:0] PA_START   = 4'd0;
   localparam logic [3:0] PB_START   = 4'd4;
   localparam logic [3:0] LAST_ROUND = 4'd11;

   typedef logic [127:0] tag_t;

   function automatic logic tag_match(input tag_t rx, input tag_t calc);
      return rx == calc;
   endfunction

endpackage

// File: rtl/round_counter.sv
// Permutation round index: loaded with the first round of pa or pb,
// steps while enabled and parks on the last round instead of wrapping.
module round_counter
   import ascon_pack::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] start,
   input  logic       en,
   output logic [3:0] round,
   output logic       last
);

   logic [3:0] cnt;

   // load has priority over stepping; stepping stops at LAST_ROUND
   always_ff @(posedge clock) begin
      if (reset)
         cnt <= 4'd0;
      else if (load)
         cnt <= start;
      else if (en && !last)
         cnt <= cnt + 4'd1;
   end

   assign round = cnt;
   assign last  = (cnt == LAST_ROUND);

endmodule

// File: rtl/ascon_dec_ctrl.sv
// ASCON-AEAD128 decryption controller: sequences init, AD absorption,
// ciphertext replacement, finalization and the tag check for the datapath.
module ascon_dec_ctrl
   import ascon_pack::*;
(
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic         ad_empty_i,
   input  logic         data_valid_i,
   input  logic         data_last_i,
   output logic         data_ready_o,
   input  logic [127:0] tag_i,
   input  logic [127:0] state_tag_i,
   output logic [3:0]   round_o,
   output logic         perm_en_o,
   output logic         init_load_o,
   output logic         key_xor_init_o,
   output logic         key_xor_final_o,
   output logic         absorb_ad_o,
   output logic         replace_ct_o,
   output logic         domain_sep_o,
   output logic         pt_valid_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         tag_ok_o
);

   state_t     state;
   logic       ad_empty_q;
   logic       ad_last_q;
   logic       tag_ok_q;
   logic       ctr_load;
   logic [3:0] ctr_start;
   logic [3:0] ctr_round;
   logic       ctr_last;

   round_counter u_round_counter (
      .clock (clock_i),
      .reset (reset_i),
      .load  (ctr_load),
      .start (ctr_start),
      .en    (perm_en_o),
      .round (ctr_round),
      .last  (ctr_last)
   );

   // Main sequencer; also latches the AD-empty flag, the last-AD flag and the tag verdict
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state      <= IDLE;
         ad_empty_q <= 1'b0;
         ad_last_q  <= 1'b0;
         tag_ok_q   <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (start_i) begin
                  state      <= LOAD;
                  ad_empty_q <= ad_empty_i;
                  tag_ok_q   <= 1'b0;
               end
            LOAD:     state <= INIT_P;
            INIT_P:   if (ctr_last) state <= KEY_INIT;
            KEY_INIT: state <= ad_empty_q ? DOMAIN : WAIT_AD;
            WAIT_AD:
               if (data_valid_i) begin
                  state     <= AD_P;
                  ad_last_q <= data_last_i;
               end
            AD_P:     if (ctr_last) state <= ad_last_q ? DOMAIN : WAIT_AD;
            DOMAIN:   state <= WAIT_CT;
            // the final ciphertext block skips the pb permutation
            WAIT_CT:  if (data_valid_i) state <= data_last_i ? KEY_FIN : CT_P;
            CT_P:     if (ctr_last) state <= WAIT_CT;
            KEY_FIN:  state <= FIN_P;
            FIN_P:    if (ctr_last) state <= TAG;
            TAG: begin
               tag_ok_q <= tag_match(tag_i, state_tag_i);
               state    <= IDLE;
            end
            default:  state <= IDLE;
         endcase
      end
   end

   // Strobe decode from the state register; ready and the data strobes
   // only rise on an actual handshake, and everything is forced low in reset
   always_comb begin
      data_ready_o    = 1'b0;
      round_o         = 4'd0;
      perm_en_o       = 1'b0;
      init_load_o     = 1'b0;
      key_xor_init_o  = 1'b0;
      key_xor_final_o = 1'b0;
      absorb_ad_o     = 1'b0;
      replace_ct_o    = 1'b0;
      domain_sep_o    = 1'b0;
      pt_valid_o      = 1'b0;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      ctr_load        = 1'b0;
      ctr_start       = PA_START;
      if (!reset_i) begin
         busy_o = (state != IDLE);
         case (state)
            LOAD: begin
               init_load_o = 1'b1;
               ctr_load    = 1'b1;
               ctr_start   = PA_START;
            end
            INIT_P, AD_P, CT_P, FIN_P: begin
               perm_en_o = 1'b1;
               round_o   = ctr_round;
            end
            KEY_INIT: key_xor_init_o = 1'b1;
            WAIT_AD: begin
               data_ready_o = data_valid_i;
               absorb_ad_o  = data_valid_i;
               ctr_load     = data_valid_i;
               ctr_start    = PB_START;
            end
            DOMAIN: domain_sep_o = 1'b1;
            WAIT_CT: begin
               data_ready_o = data_valid_i;
               replace_ct_o = data_valid_i;
               pt_valid_o   = data_valid_i;
               ctr_load     = data_valid_i && !data_last_i;
               ctr_start    = PB_START;
            end
            KEY_FIN: begin
               key_xor_final_o = 1'b1;
               ctr_load        = 1'b1;
               ctr_start       = PA_START;
            end
            TAG: done_o = 1'b1;
            default: ;
         endcase
      end
   end

   assign tag_ok_o = tag_ok_q && !reset_i;

endmodule

// File: tb/tb_ascon_dec_ctrl.sv
// Scoreboard bench for ascon_dec_ctrl: each operation pushes its expected
// strobe/round sequence; a negedge monitor pops and compares every active cycle.
module tb_ascon_dec_ctrl;

   localparam logic [127:0] TAGV = 128'h4F9C278211BEC9316BF68F46EE8B2EC6;

   logic         clock_i = 1'b0;
   logic         reset_i;
   logic         start_i;
   logic         ad_empty_i;
   logic         data_valid_i;
   logic         data_last_i;
   logic         data_ready_o;
   logic [127:0] tag_i;
   logic [127:0] state_tag_i;
   logic [3:0]   round_o;
   logic         perm_en_o;
   logic         init_load_o;
   logic         key_xor_init_o;
   logic         key_xor_final_o;
   logic         absorb_ad_o;
   logic         replace_ct_o;
   logic         domain_sep_o;
   logic         pt_valid_o;
   logic         busy_o;
   logic         done_o;
   logic         tag_ok_o;

   ascon_dec_ctrl dut (
      .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .ad_empty_i(ad_empty_i),
      .data_valid_i(data_valid_i), .data_last_i(data_last_i), .data_ready_o(data_ready_o),
      .tag_i(tag_i), .state_tag_i(state_tag_i), .round_o(round_o), .perm_en_o(perm_en_o),
      .init_load_o(init_load_o), .key_xor_init_o(key_xor_init_o),
      .key_xor_final_o(key_xor_final_o), .absorb_ad_o(absorb_ad_o),
      .replace_ct_o(replace_ct_o), .domain_sep_o(domain_sep_o), .pt_valid_o(pt_valid_o),
      .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct packed {
      logic init, perm, kinit, kfin, absorb, repl, dom, done, ptv, rdy;
      logic [3:0] rnd;
   } ev_t;

   ev_t  exp_q[$];
   logic tag_q[$];
   int   checks = 0;
   int   errors = 0;

   wire [14:0] outvec = {round_o, perm_en_o, init_load_o, key_xor_init_o, key_xor_final_o,
                         absorb_ad_o, replace_ct_o, domain_sep_o, pt_valid_o, busy_o,
                         done_o, tag_ok_o};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ev_t mk(input int k);
      ev_t e;
      e = '0;
      case (k)
         0: e.init  = 1'b1;
         1: e.kinit = 1'b1;
         2: begin e.absorb = 1'b1; e.rdy = 1'b1; end
         3: e.dom   = 1'b1;
         4: begin e.repl = 1'b1; e.ptv = 1'b1; e.rdy = 1'b1; end
         5: e.kfin  = 1'b1;
         default: e.done = 1'b1;
      endcase
      return e;
   endfunction

   task automatic push_perm(input int lo, input int hi);
      ev_t e;
      for (int r = lo; r <= hi; r++) begin
         e = '0;
         e.perm = 1'b1;
         e.rnd  = 4'(r);
         exp_q.push_back(e);
      end
   endtask

   // Expected strobe sequence for one decryption; cut stops after FIN_P round 4
   task automatic push_op(input logic e_ad, input int n_ad, input int n_ct, input logic cut);
      exp_q.push_back(mk(0));
      push_perm(0, 11);
      exp_q.push_back(mk(1));
      if (!e_ad)
         for (int i = 0; i < n_ad; i++) begin
            exp_q.push_back(mk(2));
            push_perm(4, 11);
         end
      exp_q.push_back(mk(3));
      for (int i = 0; i < n_ct; i++) begin
         exp_q.push_back(mk(4));
         if (i < n_ct - 1) push_perm(4, 11);
      end
      exp_q.push_back(mk(5));
      if (cut) push_perm(0, 4);
      else begin
         push_perm(0, 11);
         exp_q.push_back(mk(6));
      end
   endtask

   // Monitor: every cycle with an active strobe must match the next expected event
   initial begin
      ev_t  cur;
      logic tag_pend;
      tag_pend = 1'b0;
      forever begin
         @(negedge clock_i);
         if (tag_pend) begin
            tag_pend = 1'b0;
            if (tag_q.size() == 0) chk("tag_unexpected", 64'(1), 64'(0));
            else chk("tag_ok", 64'(tag_ok_o), 64'(tag_q.pop_front()));
         end
         cur = {init_load_o, perm_en_o, key_xor_init_o, key_xor_final_o, absorb_ad_o,
                replace_ct_o, domain_sep_o, done_o, pt_valid_o, data_ready_o, round_o};
         if (cur.init | cur.perm | cur.kinit | cur.kfin | cur.absorb | cur.repl |
             cur.dom | cur.done | cur.ptv) begin
            if (exp_q.size() == 0) chk("unexpected_event", 64'(cur), 64'(0));
            else chk("event", 64'(cur), 64'(exp_q.pop_front()));
            if (cur.done) tag_pend = 1'b1;
         end
      end
   end

   // mode: 0 plain, 1 stall in WAIT_CT, 2 stray start in AD_P, 3 reset in FIN_P round 5
   task automatic run_op(input logic e_ad, input int n_ad, input int n_ct,
                         input logic [127:0] tg, input logic exp_ok,
                         input int mode, input int exp_done);
      int   ad_cnt, ct_cnt, stall_cnt, done_cyc;
      logic seen_kf, inj, rst_hit;
      ad_cnt = 0; ct_cnt = 0; stall_cnt = 0; done_cyc = -1;
      seen_kf = 1'b0; inj = 1'b0; rst_hit = 1'b0;
      push_op(e_ad, n_ad, n_ct, mode == 3);
      if (mode != 3) tag_q.push_back(exp_ok);
      state_tag_i = TAGV;
      tag_i       = tg;
      @(posedge clock_i); #1;
      start_i      = 1'b1;
      ad_empty_i   = e_ad;
      data_valid_i = 1'b1;
      data_last_i  = (!e_ad && n_ad > 0) ? (n_ad == 1) : (n_ct == 1);
      for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
         @(posedge clock_i); #1;
         start_i = 1'b0;
         if (cyc == 0) begin
            chk("tag_ok_cleared_on_start", 64'(tag_ok_o), 64'(0));
            chk("busy_in_load", 64'(busy_o), 64'(1));
         end
         if (!e_ad && ad_cnt < n_ad) data_last_i = (ad_cnt == n_ad - 1);
         else                        data_last_i = (ct_cnt == n_ct - 1);
         data_valid_i = 1'b1;
         if (mode == 1 && ct_cnt == 1 && stall_cnt < 18) begin
            data_valid_i = 1'b0;
            stall_cnt++;
         end
         if (mode == 2 && !inj && ad_cnt == n_ad && ct_cnt == 0 && perm_en_o &&
             round_o == 4'd6) begin
            start_i = 1'b1;
            inj     = 1'b1;
         end
         if (mode == 3 && seen_kf && perm_en_o && round_o == 4'd5) begin
            reset_i = 1'b1;
            rst_hit = 1'b1;
            break;
         end
         #1;
         if (mode == 1 && stall_cnt >= 9 && !data_valid_i)
            chk("stall_outputs", 64'(outvec), 64'(15'h0004));
         if (absorb_ad_o)     ad_cnt++;
         if (replace_ct_o)    ct_cnt++;
         if (key_xor_final_o) seen_kf = 1'b1;
         if (done_o)          done_cyc = cyc;
      end
      start_i = 1'b0;
      if (mode == 3) begin
         chk("reset_reached_fin5", 64'(rst_hit), 64'(1));
         @(posedge clock_i); #1;
         chk("reset_outputs", 64'({data_ready_o, outvec}), 64'(0));
         reset_i      = 1'b0;
         data_valid_i = 1'b0;
         repeat (5) begin
            @(posedge clock_i); #1;
            chk("no_done_after_reset", 64'({done_o, busy_o}), 64'(0));
         end
      end else begin
         chk("done_cycle", 64'(done_cyc), 64'(exp_done));
         data_valid_i = 1'b0;
         repeat (2) @(posedge clock_i);
      end
   endtask

   initial begin
      reset_i = 1'b1; start_i = 1'b0; ad_empty_i = 1'b0;
      data_valid_i = 1'b0; data_last_i = 1'b0;
      tag_i = '0; state_tag_i = '0;
      @(posedge clock_i); #1;
      chk("outputs_in_reset", 64'({data_ready_o, outvec}), 64'(0));
      repeat (2) @(posedge clock_i);
      #1 reset_i = 1'b0;
      @(posedge clock_i); #1;
      chk("idle_after_reset", 64'({data_ready_o, outvec}), 64'(0));

      // TAG cycle index counted from the LOAD cycle (= 0)
      run_op(1'b0, 1, 2, TAGV,                  1'b1, 0, 47);
      run_op(1'b0, 1, 2, TAGV ^ 128'h1,         1'b0, 0, 47);
      run_op(1'b1, 0, 2, TAGV,                  1'b1, 0, 38);
      run_op(1'b1, 0, 1, TAGV,                  1'b1, 0, 29);
      run_op(1'b0, 2, 3, TAGV,                  1'b1, 0, 65);
      run_op(1'b0, 1, 2, TAGV,                  1'b1, 1, 57);
      run_op(1'b0, 1, 2, TAGV,                  1'b1, 2, 47);
      run_op(1'b0, 1, 2, TAGV,                  1'b1, 3, 0);
      run_op(1'b0, 1, 2, TAGV ^ 128'h1,         1'b0, 0, 47);

      repeat (3) @(posedge clock_i);
      chk("event_queue_drained", 64'(exp_q.size()), 64'(0));
      chk("tag_queue_drained", 64'(tag_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
